// File: rtl/cardinal_nic_if.sv
// Processor and router side signals of the NIC, bundled with modports.
// slave = NIC view, master = the processor/router driving it.
interface cardinal_nic_if #(
  parameter int DW = 64
);
  logic [1:0]    addr;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          nicEn;
  logic          nicWrEn;
  logic          net_si;
  logic          net_ri;
  logic [DW-1:0] net_di;
  logic          net_so;
  logic          net_ro;
  logic [DW-1:0] net_do;
  logic          net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal NIC: single-entry input and output flit buffers between a
// memory-mapped processor port and a polarity-gated router link.
module cardinal_nic #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  cardinal_nic_if.slave nic
);
  localparam logic [1:0] A_IN_DATA  = 2'b00;
  localparam logic [1:0] A_IN_FULL  = 2'b01;
  localparam logic [1:0] A_OUT_DATA = 2'b10;
  localparam logic [1:0] A_OUT_FULL = 2'b11;

  logic [DW-1:0] in_buf_q,  in_buf_d;
  logic [DW-1:0] out_buf_q, out_buf_d;
  logic [DW-1:0] d_out_q,   d_out_d;
  logic          in_full_q, in_full_d;
  logic          out_full_q, out_full_d;
  logic          rd, wr;

  assign rd = nic.nicEn & ~nic.nicWrEn;
  assign wr = nic.nicEn &  nic.nicWrEn;

  // Router handshake: accept only when empty; send only on matching phase.
  assign nic.net_ri = ~in_full_q;
  assign nic.net_do = out_buf_q;
  assign nic.net_so = out_full_q & nic.net_ro & (out_buf_q[DW-1] == nic.net_polarity);
  assign nic.d_out  = d_out_q;

  // Next-state for both buffers and the registered read port.
  // Capture (needs empty) and drain-by-read (needs full) are mutually
  // exclusive, as are send (needs full) and processor write (needs empty),
  // so pre-edge flags settle same-edge collisions.
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;

    if (nic.net_si && !in_full_q) begin
      in_buf_d  = nic.net_di;
      in_full_d = 1'b1;
    end

    if (rd) begin
      case (nic.addr)
        A_IN_DATA: begin
          d_out_d = in_buf_q;
          if (in_full_q) in_full_d = 1'b0;
        end
        A_IN_FULL:  d_out_d = {{(DW-1){1'b0}}, in_full_q};
        A_OUT_FULL: d_out_d = {{(DW-1){1'b0}}, out_full_q};
        default:    d_out_d = d_out_q;
      endcase
    end

    if (nic.net_so) out_full_d = 1'b0;

    if (wr && nic.addr == A_OUT_DATA && !out_full_q) begin
      out_buf_d  = nic.d_in;
      out_full_d = 1'b1;
    end
  end

  // State registers; reset discards both buffers at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: hand-computed expectations per step.
module tb_cardinal_nic;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cardinal_nic_if #(.DW(DW)) bus ();

  cardinal_nic #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .nic   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may be changed right after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.net_si  = 1'b0;
  endtask

  task automatic pwrite(input logic [1:0] a, input logic [DW-1:0] d);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = d;
  endtask

  task automatic pread(input logic [1:0] a);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
  endtask

  initial begin
    bus.addr = 2'b00; bus.d_in = '0; bus.net_di = '0;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    idle();
    #2;
    chk("rst_ri", {63'd0, bus.net_ri}, 64'd1);
    chk("rst_so", {63'd0, bus.net_so}, 64'd0);
    chk("rst_do", bus.net_do, 64'd0);
    chk("rst_dout", bus.d_out, 64'd0);
    step(); step();
    reset = 1'b1;

    // Basic send with matching polarity
    pwrite(2'b10, 64'h0000_0000_ABCD_ABCD);
    bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
    step(); idle();
    chk("send_so", {63'd0, bus.net_so}, 64'd1);
    chk("send_do", bus.net_do, 64'h0000_0000_ABCD_ABCD);
    step();
    chk("send_so_clr", {63'd0, bus.net_so}, 64'd0);
    pread(2'b11); step(); idle();
    chk("send_flag0", bus.d_out, 64'd0);

    // Polarity mismatch holds the flit
    pwrite(2'b10, 64'h8000_0000_0000_0001);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("pol_hold_so", {63'd0, bus.net_so}, 64'd0);
      step();
    end
    pread(2'b11); step(); idle();
    chk("pol_hold_flag", bus.d_out, 64'd1);
    bus.net_polarity = 1'b1; #1;
    chk("pol_match_so", {63'd0, bus.net_so}, 64'd1);
    step();
    chk("pol_once_so", {63'd0, bus.net_so}, 64'd0);
    bus.net_polarity = 1'b0; bus.net_ro = 1'b0;

    // Write while full is dropped
    pwrite(2'b10, 64'h1111); step();
    pwrite(2'b10, 64'h5555); step(); idle();
    chk("drop_do", bus.net_do, 64'h1111);
    bus.net_ro = 1'b1; #1;
    chk("drop_so", {63'd0, bus.net_so}, 64'd1);
    chk("drop_do2", bus.net_do, 64'h1111);
    step();
    chk("drop_so_clr", {63'd0, bus.net_so}, 64'd0);
    bus.net_ro = 1'b0;

    // Send and write on the same edge: write dropped, buffer ends empty
    pwrite(2'b10, 64'h2222); step();
    bus.net_ro = 1'b1; pwrite(2'b10, 64'h3333); step(); idle();
    bus.net_ro = 1'b0;
    chk("coll_do", bus.net_do, 64'h2222);
    pread(2'b11); step(); idle();
    chk("coll_flag", bus.d_out, 64'd0);

    // Receive path
    bus.net_si = 1'b1; bus.net_di = 64'h1234; step(); idle();
    chk("rx_ri", {63'd0, bus.net_ri}, 64'd0);
    pread(2'b01); step();
    chk("rx_flag1", bus.d_out, 64'd1);
    pread(2'b00); step();
    chk("rx_data", bus.d_out, 64'h1234);
    chk("rx_ri_free", {63'd0, bus.net_ri}, 64'd1);
    pread(2'b01); step(); idle();
    chk("rx_flag0", bus.d_out, 64'd0);
    pread(2'b00); step(); idle();
    chk("rx_stale", bus.d_out, 64'h1234);

    // Delivery while full with concurrent drain read
    bus.net_si = 1'b1; bus.net_di = 64'hAAAA; step();
    chk("busy_ri", {63'd0, bus.net_ri}, 64'd0);
    bus.net_di = 64'hBBBB; pread(2'b00); step();
    bus.nicEn = 1'b0;
    chk("busy_old", bus.d_out, 64'hAAAA);
    chk("busy_ri1", {63'd0, bus.net_ri}, 64'd1);
    step(); idle();
    chk("busy_cap", {63'd0, bus.net_ri}, 64'd0);
    pread(2'b00); step(); idle();
    chk("busy_new", bus.d_out, 64'hBBBB);

    // Ignored accesses hold d_out
    pwrite(2'b00, 64'hDEAD); step();
    chk("ign_wr00", bus.d_out, 64'hBBBB);
    pread(2'b10); step();
    chk("ign_rd10", bus.d_out, 64'hBBBB);
    pwrite(2'b01, 64'hFFFF); step(); idle();
    chk("ign_wr01", bus.d_out, 64'hBBBB);
    chk("ign_ri", {63'd0, bus.net_ri}, 64'd1);

    // Asynchronous reset mid-flight
    bus.net_si = 1'b1; bus.net_di = 64'h77; step(); idle();
    pwrite(2'b10, 64'h99); step(); idle();
    chk("pre_rst_ri", {63'd0, bus.net_ri}, 64'd0);
    chk("pre_rst_do", bus.net_do, 64'h99);
    #2 reset = 1'b0;
    #1;
    chk("arst_ri", {63'd0, bus.net_ri}, 64'd1);
    chk("arst_dout", bus.d_out, 64'd0);
    chk("arst_do", bus.net_do, 64'd0);
    chk("arst_so", {63'd0, bus.net_so}, 64'd0);
    step();
    reset = 1'b1;

    // First operation after reset behaves normally
    pwrite(2'b10, 64'h42); step(); idle();
    chk("post_do", bus.net_do, 64'h42);
    pread(2'b11); step(); idle();
    chk("post_flag", bus.d_out, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 Parameter DW, default 64, flit/data width seen by processor and router.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is asynchronous and active-low; state clears while reset=0.
REQ-004 addr  input  2  register select: 00=input-buffer data, 01=input-buffer full flag, 10=output-buffer write, 11=output-buffer full flag.
REQ-005 d_in  input  DW  processor write data.
REQ-006 d_out  output  DW  registered processor read data.
REQ-007 nicEn  input  1  processor access enable.
REQ-008 nicWrEn  input  1  1=write, 0=read; ignored unless nicEn=1.
REQ-009 net_si  input  1  router-to-NIC flit valid.
REQ-010 net_ri  output  1  NIC ready to accept from router.
REQ-011 net_di  input  DW  router-to-NIC flit.
REQ-012 net_so  output  1  NIC-to-router flit valid.
REQ-013 net_ro  input  1  router ready to accept from NIC.
REQ-014 net_do  output  DW  NIC-to-router flit.
REQ-015 net_polarity  input  1  router even/odd cycle phase.

Function
REQ-016 Single-entry input buffer (in_buf, in_full) and single-entry output buffer (out_buf, out_full).
REQ-017 net_ri = ~in_full, combinational.
REQ-018 On edge with net_si=1 and net_ri=1: in_buf<=net_di, in_full<=1; net_si with net_ri=0 ignored, flit not captured.
REQ-019 Read addr 00 (nicEn=1, nicWrEn=0): d_out<=in_buf; if in_full=1, in_full<=0 same edge.
REQ-020 Read addr 00 with in_full=0: d_out<=in_buf (stale), no state change.
REQ-021 Read addr 01: d_out<={DW-1 zeros, in_full}; read addr 11: d_out<={DW-1 zeros, out_full}.
REQ-022 Reads to 10 and writes to 00/01/11 ignored; d_out holds.
REQ-023 d_out holds its value on any edge without a valid read.
REQ-024 Write addr 10 with out_full=0: out_buf<=d_in, out_full<=1.
REQ-025 Write addr 10 with out_full=1: dropped, out_buf unchanged.
REQ-026 net_do = out_buf, combinational.
REQ-027 net_so = out_full & net_ro & (out_buf[DW-1] == net_polarity), combinational.
REQ-028 On edge with net_so=1: out_full<=0; flit transferred.
REQ-029 Same edge net_so=1 and write addr 10: write evaluated against pre-edge out_full=1, dropped; out_full ends 0.
REQ-030 Same edge router delivery and processor read addr 00 with in_full=1: net_ri=0, no capture; in_full ends 0; capture possible next edge.
REQ-031 Output-buffer full-to-empty latency: one edge after net_so first asserts; input capture-to-flag visible: flag read on next edge returns 1.
REQ-032 Flit contents not inspected or modified except bit DW-1 for polarity match.

Reset
REQ-033 While reset=0: in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0; hence net_ri=1, net_so=0, net_do=0.
REQ-034 Reset asserted mid-transfer discards both buffers immediately (asynchronous), no partial flit retained.
REQ-035 After reset release first accepted edge obeys REQ-018/REQ-024 normally.

Verification
REQ-036 Write addr 10 d_in=0x0000_0000_ABCD_ABCD, net_ro=1, net_polarity=0 -> net_so=1 next cycle, net_do=0x0000_0000_ABCD_ABCD, addr 11 read returns 0 after transfer.
REQ-037 Write out_buf bit63=1, net_polarity=0 held 3 cycles -> net_so=0, out_full=1; polarity=1 -> net_so=1, one transfer.
REQ-038 net_si=1 net_di=0x1234 -> net_ri=0, addr 01 reads 1; addr 00 read -> d_out=0x1234, following addr 01 reads 0, net_ri=1.
REQ-039 Second write addr 10 while out_full=1 (net_ro=0) with d_in=0x5555 -> out_buf keeps first value; router sees only first flit.
REQ-040 Router delivers while in_full=1 plus concurrent addr 00 read -> no overwrite, old flit returned, new flit accepted on following edge.
REQ-041 reset=0 asserted between capture and read -> in_full=0, net_ri=1, d_out=0 immediately, without clock edge.
